ecc_mul_scheduler: RTL

ECC_MUL_SCHEDULER -- requirements
Module: ecc_mul_scheduler

---
 rtl/ecc_mul_scheduler.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ecc_mul_scheduler.sv
`default_nettype none
//============================================================================
// Module      : ecc_mul_scheduler
// Description : Two-requester round-robin front end for an ECC point-multiply
//               engine. Captures one job's operands, holds them stable on the
//               engine port while it computes, and returns the result to the
//               requester that owns the job.
//               Optional watchdog: define ECC_SCHED_TIMEOUT_EN to abort a job
//               after TIMEOUT RUN cycles (result zeroed, error flag set).
// Revision    : 1.0 - initial release
//============================================================================
module ecc_mul_scheduler #(
  parameter int MAX_BITS = 256,
  parameter int TIMEOUT  = 4096
) (
  input  logic                clk,
  input  logic                rst,
  // requester 0
  input  logic                r0_req,
  input  logic [MAX_BITS-1:0] r0_px,
  input  logic [MAX_BITS-1:0] r0_py,
  input  logic [MAX_BITS-1:0] r0_k,
  output logic                r0_ack,
  output logic                r0_done,
  output logic [MAX_BITS-1:0] r0_rx,
  output logic [MAX_BITS-1:0] r0_ry,
  output logic                r0_err,
  // requester 1
  input  logic                r1_req,
  input  logic [MAX_BITS-1:0] r1_px,
  input  logic [MAX_BITS-1:0] r1_py,
  input  logic [MAX_BITS-1:0] r1_k,
  output logic                r1_ack,
  output logic                r1_done,
  output logic [MAX_BITS-1:0] r1_rx,
  output logic [MAX_BITS-1:0] r1_ry,
  output logic                r1_err,
  // shared curve configuration
  input  logic [MAX_BITS-1:0] cfg_a,
  input  logic [MAX_BITS-1:0] cfg_b,
  input  logic [MAX_BITS-1:0] cfg_prime,
  input  logic [1:0]          cfg_mode,
  // point engine
  output logic                eng_valid,
  output logic [MAX_BITS-1:0] eng_a,
  output logic [MAX_BITS-1:0] eng_b,
  output logic [MAX_BITS-1:0] eng_prime,
  output logic [MAX_BITS-1:0] eng_px,
  output logic [MAX_BITS-1:0] eng_py,
  output logic [MAX_BITS-1:0] eng_k,
  output logic [1:0]          eng_mode,
  input  logic                eng_finished,
  input  logic [MAX_BITS-1:0] eng_ox,
  input  logic [MAX_BITS-1:0] eng_oy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_RESP = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  state_t              r_state;
  logic                r_ptr;     // last granted requester (0 = r0, 1 = r1)
  logic                r_gnt;     // owner of the job in flight
  logic                r_valid;
  logic                r_r0_ack;
  logic                r_r1_ack;
  logic                r_r0_done;
  logic                r_r1_done;
  logic [MAX_BITS-1:0] r_r0_rx;
  logic [MAX_BITS-1:0] r_r0_ry;
  logic [MAX_BITS-1:0] r_r1_rx;
  logic [MAX_BITS-1:0] r_r1_ry;
  logic [MAX_BITS-1:0] r_a;
  logic [MAX_BITS-1:0] r_b;
  logic [MAX_BITS-1:0] r_prime;
  logic [MAX_BITS-1:0] r_px;
  logic [MAX_BITS-1:0] r_py;
  logic [MAX_BITS-1:0] r_k;
  logic [1:0]          r_mode;

  logic                w_any_req;
  logic                w_sel;

`ifdef ECC_SCHED_TIMEOUT_EN
  // Counter only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
  localparam int              c_CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_CW-1:0] c_LIMIT = c_CW'(TIMEOUT - 1);

  logic [c_CW-1:0] r_wdog;
  logic            r_r0_err;
  logic            r_r1_err;

  assign r0_err = r_r0_err;
  assign r1_err = r_r1_err;
`else
  assign r0_err = 1'b0;
  assign r1_err = 1'b0;
`endif

  // On a tie the requester opposite the last grant wins; otherwise the sole
  // requester wins (w_sel is only meaningful when w_any_req is set).
  assign w_any_req = r0_req | r1_req;
  assign w_sel     = (r0_req & r1_req) ? ~r_ptr : r1_req;

  assign r0_ack    = r_r0_ack;
  assign r1_ack    = r_r1_ack;
  assign r0_done   = r_r0_done;
  assign r1_done   = r_r1_done;
  assign r0_rx     = r_r0_rx;
  assign r0_ry     = r_r0_ry;
  assign r1_rx     = r_r1_rx;
  assign r1_ry     = r_r1_ry;

  assign eng_valid = r_valid;
  assign eng_a     = r_a;
  assign eng_b     = r_b;
  assign eng_prime = r_prime;
  assign eng_px    = r_px;
  assign eng_py    = r_py;
  assign eng_k     = r_k;
  assign eng_mode  = r_mode;

  // Job sequencer: arbitration, operand capture, engine handshake, response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= 1'b1;
      r_gnt     <= 1'b0;
      r_valid   <= 1'b0;
      r_r0_ack  <= 1'b0;
      r_r1_ack  <= 1'b0;
      r_r0_done <= 1'b0;
      r_r1_done <= 1'b0;
      r_r0_rx   <= '0;
      r_r0_ry   <= '0;
      r_r1_rx   <= '0;
      r_r1_ry   <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_prime   <= '0;
      r_px      <= '0;
      r_py      <= '0;
      r_k       <= '0;
      r_mode    <= '0;
`ifdef ECC_SCHED_TIMEOUT_EN
      r_wdog    <= '0;
      r_r0_err  <= 1'b0;
      r_r1_err  <= 1'b0;
`endif
    end else begin
      // ack and done are single-cycle pulses
      r_r0_ack  <= 1'b0;
      r_r1_ack  <= 1'b0;
      r_r0_done <= 1'b0;
      r_r1_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            // Operands are captured on the same edge the request is sampled,
            // so the engine port is already stable for the whole LOAD cycle.
            r_state  <= S_LOAD;
            r_gnt    <= w_sel;
            r_ptr    <= w_sel;
            r_r0_ack <= ~w_sel;
            r_r1_ack <= w_sel;
            r_px     <= w_sel ? r1_px : r0_px;
            r_py     <= w_sel ? r1_py : r0_py;
            r_k      <= w_sel ? r1_k  : r0_k;
            r_a      <= cfg_a;
            r_b      <= cfg_b;
            r_prime  <= cfg_prime;
            r_mode   <= cfg_mode;
          end
        end

        S_LOAD: begin
          r_state <= S_RUN;
          r_valid <= 1'b1;
`ifdef ECC_SCHED_TIMEOUT_EN
          r_wdog  <= '0;
`endif
        end

        S_RUN: begin
          if (eng_finished) begin
            // A completion in the expiry cycle wins over the watchdog.
            r_state <= S_RESP;
            r_valid <= 1'b0;
            if (r_gnt) begin
              r_r1_rx   <= eng_ox;
              r_r1_ry   <= eng_oy;
              r_r1_done <= 1'b1;
`ifdef ECC_SCHED_TIMEOUT_EN
              r_r1_err  <= 1'b0;
`endif
            end else begin
              r_r0_rx   <= eng_ox;
              r_r0_ry   <= eng_oy;
              r_r0_done <= 1'b1;
`ifdef ECC_SCHED_TIMEOUT_EN
              r_r0_err  <= 1'b0;
`endif
            end
          end
`ifdef ECC_SCHED_TIMEOUT_EN
          else if (r_wdog == c_LIMIT) begin
            r_state <= S_RESP;
            r_valid <= 1'b0;
            if (r_gnt) begin
              r_r1_rx   <= '0;
              r_r1_ry   <= '0;
              r_r1_done <= 1'b1;
              r_r1_err  <= 1'b1;
            end else begin
              r_r0_rx   <= '0;
              r_r0_ry   <= '0;
              r_r0_done <= 1'b1;
              r_r0_err  <= 1'b1;
            end
          end else begin
            r_wdog <= r_wdog + c_CW'(1);
          end
`endif
        end

        S_RESP: begin
          r_state <= S_GAP;
        end

        S_GAP: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
